// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response bundle between the control unit and
// the ALU control sequencer.
//   master : control-unit side, drives in_valid/aluop/funct/in_tag
//   slave  : sequencer side, drives in_ready and every result/status signal
// The parameters must match those of the alu_ctrl_seq instance it is bound to.
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         aluop;
  logic [FUNCT_W-1:0] funct;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic [2:0]         alu_ctrl;
  logic [TAG_W-1:0]   out_tag;
  logic               illegal;
  logic               busy;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output in_valid, aluop, funct, in_tag,
    input  in_ready, out_valid, alu_ctrl, out_tag, illegal, busy, op_count
  );

  modport slave (
    input  in_valid, aluop, funct, in_tag,
    output in_ready, out_valid, alu_ctrl, out_tag, illegal, busy, op_count
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with a valid/ready request
// port, a multi-cycle MUL path, illegal-encoding flag and a saturating
// completed-operation counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    alu_ctrl_seq_if.slave: in_valid/in_ready/aluop/funct/in_tag in,
//          out_valid/alu_ctrl/out_tag/illegal/busy/op_count out
//
// state | meaning
// IDLE  | ready; single-cycle ops complete the cycle after acceptance
// MULTI | MUL in flight; down-counter runs to terminal count 1
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int EN_MUL     = 1,
  parameter int TAG_W      = 4,
  parameter int COUNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MUL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic       accept;
  logic [2:0] dec_code;
  logic       dec_illegal;
  logic       dec_mul;

  assign accept = bus.in_valid & bus.in_ready;

  // Illegal encodings fall back to ADD so a consumer ignoring the flag
  // still sees a harmless code.
  always_comb begin
    dec_code    = 3'b010;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (bus.aluop)
      3'b000: begin
        if (bus.funct > FUNCT_W'(5)) begin
          dec_illegal = 1'b1;
        end else begin
          case (bus.funct[2:0])
            3'd0:    dec_code = 3'b010;
            3'd1:    dec_code = 3'b101;
            3'd2:    dec_code = 3'b000;
            3'd3:    dec_code = 3'b001;
            3'd4:    dec_code = 3'b110;
            3'd5: begin
              if (EN_MUL != 0) begin
                dec_code = 3'b111;
                dec_mul  = 1'b1;
              end else begin
                dec_illegal = 1'b1;
              end
            end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      3'b001:  dec_code = 3'b010;
      3'b010:  dec_code = 3'b000;
      3'b011:  dec_code = 3'b001;
      3'b100:  dec_code = 3'b101;
      3'b101:  dec_code = 3'b110;
      3'b110:  dec_code = 3'b010;
      3'b111:  dec_code = 3'b011;
      default: dec_code = 3'b010;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    alu_ctrl_d  = alu_ctrl_q;
    out_tag_d   = out_tag_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_ctrl_d = dec_code;
          out_tag_d  = bus.in_tag;
          illegal_d  = dec_illegal;
          if (dec_mul) begin
            state_d = MULTI;
            cnt_d   = CNT_LOAD;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      MULTI: begin
        cnt_d = cnt_q - 8'd1;
        // Terminal count 1: this edge is MUL_CYCLES-1 after acceptance.
        if (cnt_q == 8'd1) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter moves on the same edge that raises out_valid.
  always_comb begin
    op_count_d = op_count_q;
    if (out_valid_d && (op_count_q != {COUNT_W{1'b1}})) begin
      op_count_d = op_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= 3'b010;
      out_tag_q   <= '0;
      illegal_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_tag_q   <= out_tag_d;
      illegal_q   <= illegal_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign bus.busy      = (state_q == MULTI);
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.illegal   = illegal_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: drives two sequencer instances with the same stimulus.
//   instance A: MUL_CYCLES=4, EN_MUL=1, COUNT_W=16
//   instance B: MUL_CYCLES=3, EN_MUL=0, COUNT_W=2
// Expected behaviour is tracked per instance as edge numbers: the edge from
// which the unit is free again, the edge at which a pending MUL completes,
// the last issued code/tag/flag and a saturating completion count.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.FUNCT_W(6), .TAG_W(4), .COUNT_W(16)) ifa ();
  alu_ctrl_seq_if #(.FUNCT_W(6), .TAG_W(4), .COUNT_W(2))  ifb ();

  alu_ctrl_seq #(.FUNCT_W(6), .MUL_CYCLES(4), .EN_MUL(1), .TAG_W(4), .COUNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  alu_ctrl_seq #(.FUNCT_W(6), .MUL_CYCLES(3), .EN_MUL(0), .TAG_W(4), .COUNT_W(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int  n_vec  = 0;
  int  n_fail = 0;
  int  edge_n = 0;

  int  mc   [2] = '{4, 3};
  bit  en   [2] = '{1'b1, 1'b0};
  int  cmax [2] = '{65535, 3};

  bit       m_init      [2];
  int       m_idle_from [2];
  bit       m_pend      [2];
  int       m_pend_edge [2];
  bit [2:0] m_code      [2];
  int       m_tag       [2];
  bit       m_ill       [2];
  int       m_cnt       [2];
  bit       m_ov        [2];

  localparam bit [2:0] NONR_CODE [8] = '{3'b010, 3'b010, 3'b000, 3'b001,
                                         3'b101, 3'b110, 3'b010, 3'b011};
  localparam bit [2:0] RTYPE_CODE [5] = '{3'b010, 3'b101, 3'b000, 3'b001, 3'b110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic void ref_decode(input bit [2:0] op, input bit [5:0] f, input bit en_mul,
                                     output bit [2:0] code, output bit ill, output bit mul);
    code = 3'b010; ill = 1'b0; mul = 1'b0;
    if (op != 3'd0)                code = NONR_CODE[op];
    else if (f < 6'd5)             code = RTYPE_CODE[f];
    else if (f == 6'd5 && en_mul) begin code = 3'b111; mul = 1'b1; end
    else                           ill = 1'b1;
  endfunction

  task automatic model_edge(input int i, input bit r, input bit v, input bit [2:0] op,
                            input bit [5:0] f, input bit [3:0] t);
    bit [2:0] code;
    bit ill, mul;
    if (!r) begin
      m_init[i] = 1'b1; m_idle_from[i] = edge_n + 1; m_pend[i] = 1'b0;
      m_code[i] = 3'b010; m_tag[i] = 0; m_ill[i] = 1'b0; m_cnt[i] = 0; m_ov[i] = 1'b0;
      return;
    end
    m_ov[i] = 1'b0;
    if (m_pend[i] && edge_n == m_pend_edge[i]) begin
      m_ov[i] = 1'b1; m_pend[i] = 1'b0;
    end
    if (v && edge_n >= m_idle_from[i]) begin
      ref_decode(op, f, en[i], code, ill, mul);
      m_code[i] = code; m_tag[i] = int'(t); m_ill[i] = ill;
      if (mul) begin
        m_pend[i] = 1'b1;
        m_pend_edge[i] = edge_n + mc[i] - 1;
        m_idle_from[i] = edge_n + mc[i];
      end else begin
        m_ov[i] = 1'b1;
        m_idle_from[i] = edge_n + 1;
      end
    end
    if (m_ov[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
  endtask

  task automatic tick(input bit r, input bit v, input bit [2:0] op, input bit [5:0] f,
                      input bit [3:0] t);
    rst_n = r;
    ifa.in_valid = v; ifa.aluop = op; ifa.funct = f; ifa.in_tag = t;
    ifb.in_valid = v; ifb.aluop = op; ifb.funct = f; ifb.in_tag = t;
    #1;
    if (m_init[0]) chk("a.in_ready", 32'(ifa.in_ready), 32'(r && (edge_n + 1 >= m_idle_from[0])));
    if (m_init[1]) chk("b.in_ready", 32'(ifb.in_ready), 32'(r && (edge_n + 1 >= m_idle_from[1])));
    @(posedge clk);
    edge_n++;
    model_edge(0, r, v, op, f, t);
    model_edge(1, r, v, op, f, t);
    #1;
    chk("a.out_valid", 32'(ifa.out_valid), 32'(m_ov[0]));
    chk("a.alu_ctrl",  32'(ifa.alu_ctrl),  32'(m_code[0]));
    chk("a.out_tag",   32'(ifa.out_tag),   32'(m_tag[0]));
    chk("a.illegal",   32'(ifa.illegal),   32'(m_ill[0]));
    chk("a.busy",      32'(ifa.busy),      32'(m_pend[0]));
    chk("a.op_count",  32'(ifa.op_count),  32'(m_cnt[0]));
    chk("b.out_valid", 32'(ifb.out_valid), 32'(m_ov[1]));
    chk("b.alu_ctrl",  32'(ifb.alu_ctrl),  32'(m_code[1]));
    chk("b.out_tag",   32'(ifb.out_tag),   32'(m_tag[1]));
    chk("b.illegal",   32'(ifb.illegal),   32'(m_ill[1]));
    chk("b.busy",      32'(ifb.busy),      32'(m_pend[1]));
    chk("b.op_count",  32'(ifb.op_count),  32'(m_cnt[1]));
  endtask

  initial begin
    bit [5:0] rf;
    m_init = '{1'b0, 1'b0};
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.aluop = '0; ifa.funct = '0; ifa.in_tag = '0;
    ifb.in_valid = 1'b0; ifb.aluop = '0; ifb.funct = '0; ifb.in_tag = '0;
    @(negedge clk);

    // Reset held three cycles, then release.
    repeat (3) tick(1'b0, 1'b0, 3'd0, 6'd0, 4'd0);
    tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);

    // R-type funct 0..4 back-to-back, tags 1..5.
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 3'd0, 6'(k), 4'(k + 1));
    tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);
    chk("a.op_count_after_rtype", 32'(ifa.op_count), 32'd5);

    // Non-R-type classes ignore funct.
    for (int k = 1; k < 8; k++) tick(1'b1, 1'b1, 3'(k), 6'h3F, 4'(k + 7));
    tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);

    // MUL, then a request held from the next cycle until A takes it.
    tick(1'b1, 1'b1, 3'd0, 6'd5, 4'd9);
    repeat (4) tick(1'b1, 1'b1, 3'd1, 6'd0, 4'd10);
    repeat (2) tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);

    // MUL with a request offered only while busy: dropped by A.
    tick(1'b1, 1'b1, 3'd0, 6'd5, 4'd11);
    repeat (2) tick(1'b1, 1'b1, 3'd2, 6'd0, 4'd12);
    repeat (4) tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);

    // Illegal R-type encodings.
    tick(1'b1, 1'b1, 3'd0, 6'd7,   4'd13);
    tick(1'b1, 1'b1, 3'd0, 6'h25,  4'd14);
    tick(1'b1, 1'b0, 3'd0, 6'd0,   4'd0);

    // Reset in the middle of a MUL.
    tick(1'b1, 1'b1, 3'd0, 6'd5, 4'd15);
    tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);
    tick(1'b0, 1'b0, 3'd0, 6'd0, 4'd0);
    repeat (5) tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);

    // Five ops: B's 2-bit counter pins at 3.
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 3'd3, 6'd0, 4'(k));
    tick(1'b1, 1'b0, 3'd0, 6'd0, 4'd0);
    chk("b.op_count_saturated", 32'(ifb.op_count), 32'd3);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7),
           3'($urandom), rf, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, parametrised successor to the combinational ALU control decoder. It accepts (aluop, funct) requests through a valid/ready handshake and issues a registered ALU control code with a one-cycle output strobe. It adds a multi-cycle MUL operation that holds the unit busy for a configurable number of cycles, flags illegal encodings, and keeps a saturating completed-operation counter. It sits between the control unit and the ALU of the multi-cycle datapath.

Parameters:
FUNCT_W, 6, width of funct input; any set bit above bit 5 makes an R-type request illegal
MUL_CYCLES, 4, cycles from MUL acceptance to its out_valid; legal range 2..255
EN_MUL, 1, 1 = funct 5 decodes to MUL; 0 = funct 5 is illegal
TAG_W, 4, width of the request tag carried to the output
COUNT_W, 16, width of the saturating op counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
in_valid  in  1  request present
in_ready  out  1  unit can accept; high only in IDLE
aluop  in  3  ALU op class from main control
funct  in  FUNCT_W  R-type function field
in_tag  in  TAG_W  request tag
out_valid  out  1  one-cycle pulse, result control valid
alu_ctrl  out  3  decoded ALU control code
out_tag  out  TAG_W  tag of the completing request
illegal  out  1  qualifies out_valid; request was illegal
busy  out  1  multi-cycle op in progress
op_count  out  COUNT_W  completed ops, saturating

Behaviour:
- Control codes: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 reserved, 101 SUB, 110 SLT, 111 MUL.
- aluop 000 (R-type), by funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL (if EN_MUL), any other value illegal.
- aluop 001 ADD (addi); 010 AND; 011 OR; 100 SUB (beq); 101 SLT; 110 ADD (lw/sw); 111 XOR. funct is ignored for non-R-type requests.
- Illegal request: alu_ctrl=010, illegal=1, single-cycle path, still counted.
- Reset (rst_n=0 at an edge):
  - state IDLE; out_valid=0, alu_ctrl=010, out_tag=0, illegal=0, busy=0, op_count=0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- FSM states: IDLE, MULTI.
- Handshake: a request is accepted on an edge where in_valid & in_ready. in_valid while not ready is ignored, not latched. Inputs need not be held after acceptance.
- Single-cycle op accepted at edge k:
  - alu_ctrl, out_tag and illegal are registered at k; out_valid=1 for the cycle after k only.
  - State stays IDLE, so back-to-back accepts give out_valid every cycle.
- MUL accepted at edge k:
  - At k: state becomes MULTI, busy=1, in_ready=0, alu_ctrl=111, out_tag latched, counter loaded with MUL_CYCLES-1.
  - Each following edge decrements the counter.
  - At edge k+MUL_CYCLES-1: out_valid=1 (one cycle), busy=0, state returns to IDLE, in_ready=1.
  - So out_valid is high in the cycle following edge k+MUL_CYCLES-1, and a new request may be accepted at edge k+MUL_CYCLES.
- Outputs hold between strobes: alu_ctrl, out_tag and illegal keep their last values while out_valid=0.
- op_count increments on every out_valid pulse and saturates at 2^COUNT_W-1 (no wrap).
- Reset during MULTI aborts the op: no out_valid, and op_count is not incremented.
- No output backpressure: the consumer must take out_valid when it pulses.

Test Plan:
- Reset hold 3 cycles, then release -> all outputs at reset values, in_ready=1, op_count=0.
- aluop=000 with funct 0,1,2,3,4 back-to-back, tags 1..5 -> five consecutive out_valid pulses with alu_ctrl 010,101,000,001,110 and out_tag 1..5; op_count=5.
- aluop 001..111 with funct=6'h3F -> alu_ctrl 010,000,001,101,110,010,011; illegal=0 on all.
- aluop=000, funct=5, MUL_CYCLES=4, accepted at edge 10:
  - busy/in_ready=0 from edge 10; out_valid only after edge 13.
  - A request offered at edges 11-12 is dropped; one held from edge 11 onward is accepted at edge 14.
- aluop=000 with funct=7, then funct=6'h25 -> illegal=1, alu_ctrl=010, each counted. With EN_MUL=0, funct=5 -> illegal=1.
- Reset asserted mid-MUL -> no out_valid and op_count unchanged. With COUNT_W=2, five ops -> op_count stays 3.
